// File: rtl/led_ctrl_pkg.sv
// Shared types and sizing helpers for the status-LED blink-code scheduler.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    GAP  = 2'd3
  } led_state_e;

  // One spare bit above the largest phase length so the tick count never wraps.
  function automatic int phaseCntW(input int onTicks, input int offTicks, input int gapTicks);
    int m;
    m = onTicks;
    if (offTicks > m) m = offTicks;
    if (gapTicks > m) m = gapTicks;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Tick prescaler: pulses o_tick once every TICK_CYCLES clocks, restartable at any phase entry.
module led_tick_gen #(
  parameter int TICK_CYCLES = 1_600_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_restart,
  output logic o_tick
);

  localparam int W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic [W-1:0] cnt_q;

  assign o_tick = (cnt_q == W'(TICK_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst || i_restart || o_tick) cnt_q <= '0;
    else                              cnt_q <= cnt_q + W'(1);
  end

endmodule

// File: rtl/led_status_scheduler.sv
// Shares one status LED between prioritized requesters, each asking for an N-pulse blink code
// sequenced as ON/OFF pulses followed by a dark gap.
module led_status_scheduler
  import led_ctrl_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TICK_CYCLES = 1_600_000,
  parameter int ON_TICKS    = 2,
  parameter int OFF_TICKS   = 3,
  parameter int GAP_TICKS   = 10,
  parameter int CNT_W       = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_enable,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ*CNT_W-1:0] i_count,
  output logic                     o_led,
  output logic [NUM_REQ-1:0]       o_grant,
  output logic                     o_busy
);

  localparam int PH_W = phaseCntW(ON_TICKS, OFF_TICKS, GAP_TICKS);

  led_state_e         state_q, state_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [PH_W-1:0]    ph_q, ph_d;
  logic               led_q, led_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;

  logic               tick;
  logic               restart;
  logic               phaseDone;
  logic [PH_W-1:0]    phaseLast;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] winOneHot;
  logic [CNT_W-1:0]   winCount;
  logic               anyElig;

  // Prescaler sits at zero while idle and restarts on every phase entry.
  assign restart = (state_d != state_q) || (state_q == IDLE);

  led_tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_restart(restart),
    .o_tick   (tick)
  );

  // Fixed-priority arbiter; requesters asking for zero pulses are ignored.
  always_comb begin
    eligible  = '0;
    winOneHot = '0;
    winCount  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      eligible[k] = i_req[k] && (i_count[k*CNT_W +: CNT_W] != '0);
    end
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (eligible[k]) begin
        winOneHot    = '0;
        winOneHot[k] = 1'b1;
        winCount     = i_count[k*CNT_W +: CNT_W];
      end
    end
    anyElig = |eligible;
  end

  always_comb begin
    phaseLast = '0;
    case (state_q)
      ON:      phaseLast = PH_W'(ON_TICKS - 1);
      OFF:     phaseLast = PH_W'(OFF_TICKS - 1);
      GAP:     phaseLast = PH_W'(GAP_TICKS - 1);
      default: phaseLast = '0;
    endcase
    phaseDone = tick && (ph_q == phaseLast);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      ph_q    <= '0;
      led_q   <= 1'b0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      ph_q    <= ph_d;
      led_q   <= led_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!i_enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (anyElig)   state_d = ON;
        ON:   if (phaseDone) state_d = (rem_q == CNT_W'(1)) ? GAP : OFF;
        OFF:  if (phaseDone) state_d = ON;
        GAP:  if (phaseDone) state_d = anyElig ? ON : IDLE;
        default:             state_d = IDLE;
      endcase
    end
  end

  // A new grant is latched only when arbitration moves IDLE or GAP into ON.
  always_comb begin
    led_d   = (state_d == ON);
    grant_d = grant_q;
    rem_d   = rem_q;
    ph_d    = ph_q;
    if (state_d == IDLE) begin
      grant_d = '0;
      rem_d   = '0;
    end else if ((state_q == IDLE || state_q == GAP) && state_d == ON) begin
      grant_d = winOneHot;
      rem_d   = winCount;
    end else if (state_q == ON && state_d != ON) begin
      rem_d = rem_q - CNT_W'(1);
    end
    if (state_d != state_q) ph_d = '0;
    else if (tick)          ph_d = ph_q + PH_W'(1);
  end

  assign o_led   = led_q;
  assign o_grant = grant_q;
  assign o_busy  = (state_q != IDLE);

endmodule
